// File: rtl/guess_eval_if.sv
// Spinner-to-display bus for the guess evaluator: position, run state, guess mask in; decimal point, hit pulse, score out.
interface guess_eval_if #(
    parameter int unsigned NUM_POS = 6,
    parameter int unsigned POS_W   = 3,
    parameter int unsigned SCORE_W = 8
) ();
    logic [POS_W-1:0]   pos_i;
    logic               running_i;
    logic [NUM_POS-1:0] guess_i;
    logic               dp_o;
    logic               hit_o;
    logic [SCORE_W-1:0] score_o;

    modport master (
        output pos_i, running_i, guess_i,
        input  dp_o, hit_o, score_o
    );

    modport slave (
        input  pos_i, running_i, guess_i,
        output dp_o, hit_o, score_o
    );
endinterface

// File: rtl/guess_eval.sv
// LED spinner guess evaluator: decimal point from the guess mask, hit pulse on spin stop.
// Optional saturating hit score enabled by defining GUESS_EVAL_SCORE_EN.
module guess_eval #(
    parameter int unsigned NUM_POS = 6,
    parameter int unsigned POS_W   = 3,
    parameter int unsigned SCORE_W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    guess_eval_if.slave  bus
);

    logic running_q;
    logic dp_q, dp_d;
    logic hit_q, hit_d;
    logic sel_c;

    // Guess bit at the current position; out-of-range positions match nothing and read 0.
    always_comb begin
        sel_c = 1'b0;
        for (int unsigned k = 0; k < NUM_POS; k++) begin
            if (bus.pos_i == POS_W'(k)) begin
                sel_c = bus.guess_i[k];
            end
        end
    end

    always_comb begin
        dp_d  = ~bus.running_i & sel_c;
        hit_d = running_q & ~bus.running_i & sel_c;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            running_q <= 1'b0;
            dp_q      <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            running_q <= bus.running_i;
            dp_q      <= dp_d;
            hit_q     <= hit_d;
        end
    end

    assign bus.dp_o  = dp_q;
    assign bus.hit_o = hit_q;

`ifdef GUESS_EVAL_SCORE_EN
    logic [SCORE_W-1:0] score_q, score_d;

    // Count hits, holding at full scale instead of wrapping.
    always_comb begin
        score_d = score_q;
        if (hit_d && (score_q != {SCORE_W{1'b1}})) begin
            score_d = score_q + SCORE_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            score_q <= SCORE_W'(0);
        end else begin
            score_q <= score_d;
        end
    end

    assign bus.score_o = score_q;
`else
    assign bus.score_o = SCORE_W'(0);
`endif

endmodule

// File: tb/tb_guess_eval.sv
// Self-checking bench for guess_eval: directed scenarios plus random traffic against a rule-level model.
module tb_guess_eval;

    localparam int unsigned NUM_POS = 6;
    localparam int unsigned POS_W   = 3;
    localparam int unsigned SCORE_W = 2;

    logic clk_i;
    logic rst_n_i;

    guess_eval_if #(.NUM_POS(NUM_POS), .POS_W(POS_W), .SCORE_W(SCORE_W)) bus ();

    guess_eval #(.NUM_POS(NUM_POS), .POS_W(POS_W), .SCORE_W(SCORE_W)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_pass  = 0;

    // Model state: was the spinner running at the previous edge, and the hit tally.
    int m_prev_run = 0;
    int m_score    = 0;
    int m_hits     = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    // Apply one cycle of inputs, advance one edge, compare all outputs with the model.
    task automatic step(input int rst_n, input int run, input int pos, input int guess, input string tag);
        int on_guess;
        int exp_dp;
        int exp_hit;
        int score_max;
        score_max = (1 << SCORE_W) - 1;
        rst_n_i       = rst_n[0];
        bus.running_i = run[0];
        bus.pos_i     = POS_W'(pos);
        bus.guess_i   = NUM_POS'(guess);
        on_guess = (pos < NUM_POS) ? ((guess >> pos) & 1) : 0;
        if (rst_n == 0) begin
            exp_dp     = 0;
            exp_hit    = 0;
            m_score    = 0;
            m_prev_run = 0;
        end else begin
            exp_dp  = (run == 0) ? on_guess : 0;
            exp_hit = (m_prev_run == 1 && run == 0 && on_guess == 1) ? 1 : 0;
            if (exp_hit == 1) begin
                m_hits++;
                if (m_score < score_max) m_score++;
            end
            m_prev_run = run;
        end
        @(posedge clk_i);
        #1;
        check({tag, ".dp"},  int'(bus.dp_o),  exp_dp);
        check({tag, ".hit"}, int'(bus.hit_o), exp_hit);
`ifdef GUESS_EVAL_SCORE_EN
        check({tag, ".score"}, int'(bus.score_o), m_score);
`else
        check({tag, ".score"}, int'(bus.score_o), 0);
`endif
    endtask

    initial begin
        int hits_before;
        rst_n_i       = 1'b0;
        bus.running_i = 1'b0;
        bus.pos_i     = '0;
        bus.guess_i   = '0;

        step(0, 0, 0, 0, "reset0");
        step(0, 1, 2, 63, "reset1");

        // Spinning: never a decimal point or hit regardless of guess.
        for (int p = 0; p < 8; p++) step(1, 1, p, 63, "spin_all");

        // Stopped with empty guess.
        for (int p = 0; p < 6; p++) step(1, 0, p, 0, "stop_none");

        // Stopped with full guess, including out-of-range positions.
        for (int p = 0; p < 8; p++) step(1, 0, p, 63, "stop_all");

        // Single-bit guess: hit at position 2, miss at position 3.
        step(1, 1, 1, 6'b000100, "spin_a");
        hits_before = m_hits;
        step(1, 0, 2, 6'b000100, "stop_hit");
        check("hit_expected", m_hits - hits_before, 1);
        step(1, 0, 2, 6'b000100, "after_hit");
        step(1, 1, 3, 6'b000100, "spin_b");
        step(1, 0, 3, 6'b000100, "stop_miss");
        step(1, 0, 3, 6'b000100, "after_miss");

        // Stop then immediate restart still yields one pulse.
        step(1, 1, 2, 6'b000100, "spin_c");
        step(1, 0, 2, 6'b000100, "stop_c");
        step(1, 1, 2, 6'b000100, "restart_c");

        // Five hit stops to exercise saturation, then reset clears.
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 2, 6'b000100, "sat_spin");
            step(1, 0, 2, 6'b000100, "sat_stop");
        end
        step(0, 0, 2, 6'b000100, "sat_reset");

        // Reset pulse while stopped: no spurious hit; guess toggles show after one cycle.
        step(1, 0, 4, 6'b010000, "hold_a");
        step(0, 0, 4, 6'b010000, "hold_rst");
        step(1, 0, 4, 6'b010000, "hold_b");
        step(1, 0, 4, 6'b000000, "toggle_0");
        step(1, 0, 4, 6'b010000, "toggle_1");
        step(1, 0, 5, 6'b010000, "move_off");

        // Reset mid-spin discards the pending stop.
        step(1, 1, 4, 6'b010000, "mid_spin");
        step(0, 0, 4, 6'b010000, "mid_rst");
        step(1, 0, 4, 6'b010000, "mid_after");

        // Random traffic with run bias toward frequent stops.
        for (int i = 0; i < 400; i++) begin
            int r_rst;
            int r_run;
            r_rst = ($urandom_range(0, 39) == 0) ? 0 : 1;
            r_run = ($urandom_range(0, 2) == 0) ? 0 : 1;
            step(r_rst, r_run, int'($urandom_range(0, 7)), int'($urandom_range(0, 63)), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
